// File: rtl/rotate_issue_unit.sv
// Command stage for an external 8-bit left-rotate shifter: registers operand/amount,
// captures the shifter result one cycle later and queues it in a small result FIFO.
module rotate_issue_unit #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic [2:0]       in_amt,
    input  logic             in_dir,
    output logic [7:0]       sh_a,
    output logic [2:0]       sh_b,
    input  logic [7:0]       sh_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t           state, state_nxt;
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;
    logic             accept, wr_en, pop;

    // A right rotate by n is a left rotate by (8 - n) mod 8.
    function automatic logic [2:0] left_amt(input logic [2:0] amt, input logic dir);
        return dir ? (3'd0 - amt) : amt;
    endfunction

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                // Checking space here reserves the slot the ISSUE write will use.
                in_ready = (count < FULL);
                accept   = in_valid && in_ready;
                if (accept) state_nxt = ISSUE;
            end
            ISSUE: begin
                busy      = 1'b1;
                wr_en     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : 8'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Stage p0: command registers driving the shifter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_a <= 8'd0;
            sh_b <= 3'd0;
        end else if (accept) begin
            sh_a <= in_data;
            sh_b <= left_amt(in_amt, in_dir);
        end
    end

    // Stage p1: shifter result captured into the FIFO
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= sh_out;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ops_done <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr   <= wr_ptr + 1'b1;
                ops_done <= ops_done + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_issue_unit.sv
// Directed bench for rotate_issue_unit with a behavioural stand-in for the rotate shifter.
module tb_rotate_issue_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic       in_dir;
    logic [7:0] sh_a;
    logic [2:0] sh_b;
    logic [7:0] sh_out;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
    logic [7:0] ops_done;

    int tests  = 0;
    int failed = 0;

    rotate_issue_unit #(.DEPTH(2), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_dir(in_dir),
        .sh_a(sh_a), .sh_b(sh_b), .sh_out(sh_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    // Stand-in for the external combinational left-rotate shifter
    logic [15:0] dbl;
    always_comb begin
        dbl    = {sh_a, sh_a} << sh_b;
        sh_out = dbl[15:8];
    end

    function automatic logic [7:0] rotl(input logic [7:0] x, input logic [2:0] a);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < 8; i++) if (i < a) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] rotr(input logic [7:0] x, input logic [2:0] a);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < 8; i++) if (i < a) r = {r[0], r[7:1]};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic [2:0] amt;
        logic       dir;
        logic [2:0] shb;
        logic [7:0] res;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int         exp_ops;
        logic [7:0] q[$];
        logic [7:0] cur_exp;
        logic       acc;
        int         sent, got, cyc;

        vecs[0] = '{8'b01111011, 3'd1, 1'b0, 3'd1, 8'b11110110};
        vecs[1] = '{8'b01111011, 3'd3, 1'b0, 3'd3, 8'b11011011};
        vecs[2] = '{8'b01111011, 3'd1, 1'b1, 3'd7, 8'b10111101};
        vecs[3] = '{8'b01111011, 3'd0, 1'b1, 3'd0, 8'b01111011};
        vecs[4] = '{8'h81,       3'd2, 1'b1, 3'd6, 8'h60};
        vecs[5] = '{8'h01,       3'd7, 1'b0, 3'd7, 8'h80};
        vecs[6] = '{8'hA5,       3'd4, 1'b1, 3'd4, 8'h5A};
        vecs[7] = '{8'h3C,       3'd5, 1'b1, 3'd3, 8'hE1};

        reset = 1'b1; in_valid = 1'b0; in_data = 8'd0; in_amt = 3'd0; in_dir = 1'b0; out_ready = 1'b0;
        step(); step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_ops_done", ops_done, 0);
        check("rst_busy", busy, 0);
        check("rst_sh_a", sh_a, 0);
        check("rst_sh_b", sh_b, 0);
        reset = 1'b0;
        step();
        check("rst_in_ready", in_ready, 1);

        exp_ops = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = vecs[i].data; in_amt = vecs[i].amt; in_dir = vecs[i].dir;
            check($sformatf("v%0d_in_ready", i), in_ready, 1);
            step();
            in_valid = 1'b0;
            check($sformatf("v%0d_busy", i), busy, 1);
            check($sformatf("v%0d_sh_a", i), sh_a, vecs[i].data);
            check($sformatf("v%0d_sh_b", i), sh_b, vecs[i].shb);
            check($sformatf("v%0d_early_valid", i), out_valid, 0);
            step();
            exp_ops++;
            check($sformatf("v%0d_out_valid", i), out_valid, 1);
            check($sformatf("v%0d_out_data", i), out_data, vecs[i].res);
            check($sformatf("v%0d_ops_done", i), ops_done, exp_ops);
            check($sformatf("v%0d_idle", i), busy, 0);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check($sformatf("v%0d_popped", i), out_valid, 0);
            check($sformatf("v%0d_empty_data", i), out_data, 0);
        end

        // Back-pressure: fill the FIFO, hold off a third command, then drain.
        in_valid = 1'b1; in_data = 8'h11; in_amt = 3'd1; in_dir = 1'b0;
        step();
        in_data = 8'h48; in_amt = 3'd2; in_dir = 1'b1;
        check("bp_issue_not_ready", in_ready, 0);
        step();
        check("bp_ready_after_1", in_ready, 1);
        check("bp_head_a", out_data, 8'h22);
        step();
        check("bp_busy_b", busy, 1);
        step();
        exp_ops += 2;
        check("bp_full_not_ready", in_ready, 0);
        check("bp_full_head", out_data, 8'h22);
        check("bp_full_ops", ops_done, exp_ops);
        in_data = 8'hF0; in_amt = 3'd4; in_dir = 1'b0;
        step(); step();
        check("bp_held_off_ready", in_ready, 0);
        check("bp_held_off_busy", busy, 0);
        check("bp_held_off_ops", ops_done, exp_ops);
        out_ready = 1'b1;
        check("bp_pop_same_cycle", in_ready, 0);
        step();
        check("bp_head_b", out_data, 8'h12);
        check("bp_ready_after_pop", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("bp_c_busy", busy, 1);
        check("bp_c_sh_a", sh_a, 8'hF0);
        check("bp_drained", out_valid, 0);
        step();
        exp_ops++;
        check("bp_c_valid", out_valid, 1);
        check("bp_c_data", out_data, 8'h0F);
        check("bp_c_ops", ops_done, exp_ops);
        step();
        out_ready = 1'b0;
        check("bp_c_popped", out_valid, 0);

        // Write and pop in the same cycle with one entry queued.
        in_valid = 1'b1; in_data = 8'h0F; in_amt = 3'd4; in_dir = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("sim_head_d", out_data, 8'hF0);
        in_valid = 1'b1; in_data = 8'h80; in_amt = 3'd1; in_dir = 1'b0;
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_ops += 2;
        check("sim_valid", out_valid, 1);
        check("sim_head_e", out_data, 8'h01);
        check("sim_ops", ops_done, exp_ops);
        step();
        check("sim_hold_head", out_data, 8'h01);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("sim_count_was_1", out_valid, 0);

        // Reset while a command is in flight and the FIFO holds a result.
        in_valid = 1'b1; in_data = 8'h55; in_amt = 3'd1; in_dir = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        in_valid = 1'b1; in_data = 8'h33; in_amt = 3'd2;
        step();
        in_valid = 1'b0;
        check("mid_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_ops", ops_done, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sh_a", sh_a, 0);
        step();
        reset = 1'b0;
        step(); step();
        check("post_rst_valid", out_valid, 0);
        check("post_rst_ops", ops_done, 0);
        check("post_rst_ready", in_ready, 1);

        // 256 streamed commands against the reference model; ops_done wraps.
        sent = 0; got = 0; cyc = 0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'($urandom); in_amt = 3'($urandom); in_dir = 1'($urandom);
        cur_exp = in_dir ? rotr(in_data, in_amt) : rotl(in_data, in_amt);
        while ((sent < 256 || q.size() != 0) && cyc < 3000) begin
            if (out_valid) begin
                check("wrap_has_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    check("wrap_data", out_data, q.pop_front());
                    got++;
                end
            end
            acc = in_valid && in_ready;
            step();
            cyc++;
            if (acc) begin
                q.push_back(cur_exp);
                sent++;
                if (sent < 256) begin
                    in_data = 8'($urandom); in_amt = 3'($urandom); in_dir = 1'($urandom);
                    cur_exp = in_dir ? rotr(in_data, in_amt) : rotl(in_data, in_amt);
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (sent == 255 && !busy && q.size() == 0)
                check("wrap_ops_255", ops_done, 255);
        end
        check("wrap_no_timeout", cyc < 3000, 1);
        check("wrap_results", got, 256);
        check("wrap_ops_done", ops_done, 0);
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
